// File: rtl/lsu_mem_responder.sv
// Load/store responder between the decoder's memory controls and a synchronous BRAM port.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses are trapped instead of force-aligned.
module lsu_mem_responder #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic [3:0]        MemWrite,
    input  logic [1:0]        MemReadSize,
    input  logic              MemReadSigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              stall,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RWAIT, S_RESP} state_t;

    localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [1:0]  cnt_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sgn_q;

    logic        is_store, is_load, size_half, size_word, misalign, trap;
    logic        accept, access;
    logic [1:0]  off_d;
    logic [31:0] lane_b, lane_h, ext_d;

    assign is_store = |MemWrite;
    assign is_load  = MemRead & ~is_store;

    // Access width comes from the byte mask for stores, from MemReadSize for loads.
    always_comb begin
        size_half = 1'b0;
        size_word = 1'b0;
        if (is_store) begin
            size_half = (MemWrite == 4'b0011);
            size_word = (MemWrite == 4'b1111);
        end else if (is_load) begin
            size_half = (MemReadSize == 2'd1);
            size_word = MemReadSize[1];
        end
    end

    assign misalign = (size_half & addr[0]) | (size_word & (|addr[1:0]));

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap  = misalign;
    assign off_d = addr[1:0];
`else
    assign trap = 1'b0;
    always_comb begin
        off_d = addr[1:0];
        if (size_word)      off_d = 2'b00;
        else if (size_half) off_d[0] = 1'b0;
    end
`endif

    assign accept = req_valid & req_ready_q;
    assign access = accept & (is_store | is_load) & ~trap;

    assign mem_en    = access;
    assign mem_we    = (access & is_store) ? (MemWrite << off_d) : 4'b0000;
    assign mem_addr  = access ? addr[ADDR_W-1:2] : '0;
    assign mem_wdata = access ? (wdata << {off_d, 3'b000}) : 32'd0;

    // Extraction uses the request fields latched at accept.
    assign lane_b = mem_rdata >> {off_q, 3'b000};
    assign lane_h = mem_rdata >> {off_q[1], 4'b0000};

    always_comb begin
        case (size_q)
            2'd0:    ext_d = {{24{sgn_q & lane_b[7]}}, lane_b[7:0]};
            2'd1:    ext_d = {{16{sgn_q & lane_h[15]}}, lane_h[15:0]};
            default: ext_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= 2'd0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            sgn_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        off_q       <= off_d;
                        size_q      <= MemReadSize;
                        sgn_q       <= MemReadSigned;
                        cnt_q       <= 2'd0;
                        req_ready_q <= 1'b0;
                        if (is_load & ~trap) begin
                            state_q <= S_RWAIT;
                        end else begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= trap;
                            rsp_rdata_q <= 32'd0;
                        end
                    end
                end
                S_RWAIT: begin
                    if (cnt_q == LAT_LAST) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= ext_d;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                    rsp_err_q   <= 1'b0;
                    cnt_q       <= 2'd0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign stall     = (req_valid & ~req_ready_q) | (state_q != S_IDLE);

endmodule
